// File: rtl/spi_master_ctrl.sv
// SPI master controller: turns parallel host commands into SS_n/MOSI frames
// and captures the 8-bit MISO reply of read-data commands.
module spi_master_ctrl #(
  parameter int unsigned MISO_LATENCY = 2,  // cycles from last MOSI bit to first MISO bit (1..15)
  parameter int unsigned GAP_CYCLES   = 1   // minimum SS_n-high cycles between frames (1..15)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SHIFT,
    WAIT,
    RECV,
    GAP
  } state_t;

  localparam logic [1:0] TYPE_READ_DATA = 2'b11;
  localparam logic [3:0] SHIFT_LAST     = 4'd9;
  localparam logic [3:0] RECV_LAST      = 4'd7;
  localparam logic [3:0] WAIT_LAST      = 4'(MISO_LATENCY - 1);
  localparam logic [3:0] GAP_LAST       = 4'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [9:0]  frame, frame_nxt;
  logic [3:0]  bit_idx;
  logic        accept;
  logic        ss_n_nxt;
  logic        mosi_nxt;
  logic        recv_last;
  logic [7:0]  shreg;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign recv_last = (state == RECV) && (cnt == RECV_LAST);

  // Next-state, per-state cycle counter, and the values SS_n/MOSI take next cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    frame_nxt = frame;
    mosi_nxt  = 1'b0;
    bit_idx   = 4'd0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEL;
          cnt_nxt   = 4'd0;
          // Read-data frames carry a dummy 0x00 payload.
          frame_nxt = {cmd_type, (cmd_type == TYPE_READ_DATA) ? 8'h00 : cmd_data};
        end
      end
      SEL: begin
        state_nxt = SHIFT;
        cnt_nxt   = 4'd0;
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = (frame[9:8] == TYPE_READ_DATA) ? WAIT : GAP;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = RECV;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RECV: begin
        if (cnt == RECV_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    // SS_n and MOSI are registered from the upcoming state so the pins
    // come straight from flops and line up with the state they belong to.
    ss_n_nxt = !(state_nxt inside {SEL, SHIFT, WAIT, RECV});
    case (state_nxt)
      SEL:     mosi_nxt = frame_nxt[9];
      SHIFT: begin
        bit_idx  = SHIFT_LAST - cnt_nxt;
        mosi_nxt = frame_nxt[bit_idx];
      end
      default: mosi_nxt = 1'b0;
    endcase
  end

  // Control state and the serial output pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      frame <= 10'd0;
      SS_n  <= 1'b1;
      MOSI  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      frame <= frame_nxt;
      SS_n  <= ss_n_nxt;
      MOSI  <= mosi_nxt;
    end
  end

  // MISO capture, MSB first, and the one-cycle response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the capture register is reset too, so a byte cut short by a
      // mid-frame reset can never surface on rsp_data later.
      shreg     <= 8'h00;
      rsp_data  <= 8'h00;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == RECV) begin
        shreg <= {shreg[6:0], MISO};
      end
      if (recv_last) begin
        rsp_data  <= {shreg[6:0], MISO};
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with a behavioural SPI slave + RAM.
module tb_spi_master_ctrl;

  localparam int L = 2;  // MISO_LATENCY
  localparam int G = 1;  // GAP_CYCLES

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  int total = 0;
  int bad   = 0;

  spi_master_ctrl #(.MISO_LATENCY(L), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (host-level view) ----------------
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_addr = 8'h00;
  int          exp_len_q[$];
  logic [31:0] exp_bits_q[$];
  logic [7:0]  exp_rsp_q[$];

  task automatic model_cmd(input logic [1:0] t, input logic [7:0] d);
    logic [10:0] f;
    logic [7:0]  p;
    p = (t == 2'b11) ? 8'h00 : d;
    f = {t[1], t, p};  // mode bit in the select cycle, then the 10-bit frame
    if (t == 2'b11) begin
      exp_len_q.push_back(11 + L + 8);
      exp_bits_q.push_back(32'(f) << (L + 8));
      exp_rsp_q.push_back(ref_mem[ref_addr]);
    end else begin
      exp_len_q.push_back(11);
      exp_bits_q.push_back(32'(f));
      if (t == 2'b01) ref_mem[ref_addr] = d;
      else            ref_addr = d;
    end
  endtask

  // ---------------- slave model + bus monitor ----------------
  logic [7:0]  s_mem [256];
  logic [7:0]  s_addr = 8'h00;
  logic [7:0]  s_reply = 8'h00;
  int          mcnt = 0;
  logic [31:0] mbits = '0;
  bit          in_frame = 0;
  bit          have_prev = 0;
  int          hi_cnt = 0;
  int          frm_len_q[$];
  logic [31:0] frm_bits_q[$];
  int          hi_q[$];
  logic [7:0]  rsp_q[$];
  int          rsp_pos_q[$];

  // Everything sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 0;
      have_prev = 0;
      mcnt      = 0;
      hi_cnt    = 0;
      MISO      = 1'b0;
    end else begin
      if (!SS_n) begin
        if (!in_frame) begin
          if (have_prev) hi_q.push_back(hi_cnt);
          in_frame = 1;
          mcnt     = 0;
          mbits    = '0;
        end
        mcnt++;
        mbits = {mbits[30:0], MOSI};
        if (mcnt == 11) begin
          case (mbits[9:8])
            2'b00, 2'b10: s_addr = mbits[7:0];
            2'b01:        s_mem[s_addr] = mbits[7:0];
            default:      s_reply = s_mem[s_addr];
          endcase
        end
        // Reply bits occupy the 8 cycles that start L cycles after the last frame bit.
        if (mcnt >= 12 + L && mcnt <= 19 + L) MISO = s_reply[19 + L - mcnt];
        else                                   MISO = 1'b0;
      end else begin
        if (in_frame) begin
          frm_len_q.push_back(mcnt);
          frm_bits_q.push_back(mbits);
          in_frame  = 0;
          have_prev = 1;
          hi_cnt    = 0;
        end
        hi_cnt++;
        MISO = 1'b0;
      end
      if (rsp_valid) begin
        rsp_q.push_back(rsp_data);
        rsp_pos_q.push_back(SS_n ? hi_cnt : 0);
      end
    end
  end

  // ---------------- host-side helpers ----------------
  task automatic flush_all();
    exp_len_q.delete(); exp_bits_q.delete(); exp_rsp_q.delete();
    frm_len_q.delete(); frm_bits_q.delete(); hi_q.delete();
    rsp_q.delete(); rsp_pos_q.delete();
  endtask

  task automatic wait_ready(input string who);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL %s: cmd_ready timeout, got 0 want 1", who);
    end
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [7:0] d);
    wait_ready("send_cmd");
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_data  = 8'($urandom);
    model_cmd(t, d);
  endtask

  task automatic wait_idle(input string who);
    int k = 0;
    @(negedge clk);
    while ((busy || !SS_n) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL %s: idle timeout, busy=%0b want 0", who, busy);
    end
    repeat (3) @(negedge clk);
  endtask

  // Compares every observed frame and response against the model queues.
  task automatic compare_scoreboard(input string who);
    while (exp_len_q.size() > 0) begin
      int          el, ol;
      logic [31:0] eb, ob;
      el = exp_len_q.pop_front();
      eb = exp_bits_q.pop_front();
      total++;
      if (frm_len_q.size() == 0) begin
        bad++;
        $display("FAIL %s frame missing: got none want len=%0d bits=%h", who, el, eb);
      end else begin
        ol = frm_len_q.pop_front();
        ob = frm_bits_q.pop_front();
        if (ol !== el) begin
          bad++;
          $display("FAIL %s frame len: got %0d want %0d", who, ol, el);
        end
        total++;
        if (ob !== eb) begin
          bad++;
          $display("FAIL %s frame mosi: got %h want %h", who, ob, eb);
        end
      end
    end
    total++;
    if (frm_len_q.size() != 0) begin
      bad++;
      $display("FAIL %s extra frames: got %0d want 0", who, frm_len_q.size());
    end
    while (exp_rsp_q.size() > 0) begin
      logic [7:0] er, orr;
      int         pos;
      er = exp_rsp_q.pop_front();
      total++;
      if (rsp_q.size() == 0) begin
        bad++;
        $display("FAIL %s rsp missing: got none want %h", who, er);
      end else begin
        orr = rsp_q.pop_front();
        pos = rsp_pos_q.pop_front();
        if (orr !== er) begin
          bad++;
          $display("FAIL %s rsp_data: got %h want %h", who, orr, er);
        end
        total++;
        if (pos < 1 || pos > G + 1) begin
          bad++;
          $display("FAIL %s rsp timing: got gap cycle %0d want 1..%0d", who, pos, G + 1);
        end
      end
    end
    total++;
    if (rsp_q.size() != 0) begin
      bad++;
      $display("FAIL %s extra rsp_valid: got %0d want 0", who, rsp_q.size());
    end
    flush_all();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (SS_n !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got SS_n=%b busy=%b want 1 0", SS_n, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({SS_n, MOSI, cmd_ready, rsp_valid, busy} !== 5'b10100) begin
      bad++;
      $display("FAIL reset_outputs: got SS_n,MOSI,ready,rsp_valid,busy=%b want 10100",
               {SS_n, MOSI, cmd_ready, rsp_valid, busy});
    end
    total++;
    if (rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rsp_data: got %h want 00", rsp_data);
    end
  endtask

  task automatic test_write_addr();
    int k = 0;
    flush_all();
    send_cmd(2'b00, 8'h3A);
    while (SS_n && k < 20) begin @(negedge clk); k++; end
    while (!SS_n && k < 60) begin @(negedge clk); k++; end
    // First SS_n-high cycle is the gap; ready appears on high cycle G+1.
    k = 1;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    total++;
    if (k != G + 1) begin
      bad++;
      $display("FAIL write_addr ready_after_gap: got high cycle %0d want %0d", k, G + 1);
    end
    wait_idle("write_addr");
    total++;
    if (frm_len_q.size() != 1 || frm_len_q[0] != 11 || frm_bits_q[0] !== 32'h0000_003A) begin
      bad++;
      $display("FAIL write_addr frame: got n=%0d len=%0d bits=%h want n=1 len=11 bits=0000003a",
               frm_len_q.size(), (frm_len_q.size() > 0) ? frm_len_q[0] : -1,
               (frm_bits_q.size() > 0) ? frm_bits_q[0] : 32'hx);
    end
    compare_scoreboard("write_addr");
  endtask

  task automatic test_round_trip();
    flush_all();
    send_cmd(2'b00, 8'h3A);
    send_cmd(2'b01, 8'hC5);
    send_cmd(2'b10, 8'h3A);
    send_cmd(2'b11, 8'h00);
    wait_idle("round_trip");
    total++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 8'hC5) begin
      bad++;
      $display("FAIL round_trip rsp: got n=%0d data=%h want n=1 data=c5",
               rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 8'hx);
    end
    total++;
    if (frm_len_q.size() != 4 || frm_len_q[3] != 11 + L + 8) begin
      bad++;
      $display("FAIL round_trip read_len: got %0d want %0d",
               (frm_len_q.size() == 4) ? frm_len_q[3] : -1, 11 + L + 8);
    end
    compare_scoreboard("round_trip");
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    flush_all();
    have_prev = 0;
    wait_ready("b2b_start");
    cmd_valid = 1'b1;
    cmd_type  = 2'b01;
    cmd_data  = vals[0];
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_ready("b2b");
      @(posedge clk);
      #1;
      model_cmd(2'b01, vals[i]);
      if (i < 3) cmd_data = vals[i + 1];
      else       cmd_valid = 1'b0;
    end
    wait_idle("back_to_back");
    total++;
    if (hi_q.size() != 3) begin
      bad++;
      $display("FAIL b2b gaps: got %0d gaps want 3", hi_q.size());
    end
    foreach (hi_q[i]) begin
      total++;
      if (hi_q[i] != G + 1) begin
        bad++;
        $display("FAIL b2b gap_len[%0d]: got %0d want %0d", i, hi_q[i], G + 1);
      end
    end
    compare_scoreboard("back_to_back");
  endtask

  task automatic test_busy_reject();
    int k = 0;
    flush_all();
    send_cmd(2'b01, 8'($urandom));
    while (SS_n && k < 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = 2'b10;
    cmd_data  = 8'($urandom);
    total++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_reject ready: got ready=%b busy=%b want 0 1", cmd_ready, busy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("busy_reject");
    repeat (5) @(negedge clk);
    compare_scoreboard("busy_reject");
  endtask

  task automatic test_reset_mid_read();
    int         k = 0;
    logic [7:0] a, d;
    a = 8'($urandom);
    d = 8'($urandom);
    flush_all();
    send_cmd(2'b00, a);
    send_cmd(2'b01, d);
    send_cmd(2'b10, a);
    wait_idle("reset_mid_read_setup");
    compare_scoreboard("reset_mid_read_setup");
    send_cmd(2'b11, 8'h00);
    // Stop at RECV bit 4: cycle 11 + L + 1 + 4 of the low phase.
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (!(in_frame && mcnt == 16 + L) && k < 80);
    rst_n = 1'b0;
    #1;
    total++;
    if (SS_n !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_read async: got SS_n=%b rsp_valid=%b want 1 0", SS_n, rsp_valid);
    end
    repeat (2) @(negedge clk);
    total++;
    if (rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_read rsp_data: got %h want 00", rsp_data);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rsp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_read rsp_valid: got %0d pulses want 0", rsp_q.size());
    end
    flush_all();
    send_cmd(2'b11, 8'h00);
    wait_idle("reset_mid_read_retry");
    total++;
    if (rsp_q.size() != 1 || rsp_q[0] !== d) begin
      bad++;
      $display("FAIL mid_read retry: got n=%0d data=%h want n=1 data=%h",
               rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 8'hx, d);
    end
    compare_scoreboard("reset_mid_read_retry");
  endtask

  task automatic test_random();
    flush_all();
    for (int i = 0; i < 30; i++) begin
      logic [1:0] t;
      logic [7:0] d;
      t = 2'($urandom);
      d = (t[0] == 1'b0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      send_cmd(t, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("random");
    compare_scoreboard("random");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      s_mem[i]   = 8'h00;
    end
    test_reset();
    test_write_addr();
    test_round_trip();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
